// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Round controller for the AES encrypt datapath. Walks the HLS sub-blocks
//   through one block encryption using their ap_start/ap_done handshakes:
//     ARK(0); rounds 1..NR-1: SB, SR, MC, ARK(r); final round: SB, SR, ARK(NR)
//   then pulses ap_done/ap_ready for one cycle and returns to idle.
//
// Ports
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   ap_start                request one encryption (sampled only while idle)
//   ap_done, ap_ready       one-cycle completion pulse (same cycle)
//   ap_idle                 idle and no request pending
//   ark_start / ark_done    add_round_key handshake
//   ark_n                   round index for add_round_key, valid during ARK
//   sb_start / sb_done      sub_bytes handshake
//   sr_start / sr_done      shift_row handshake
//   mc_start / mc_done      mix_column handshake
//   round                   current round counter (status)
module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter int ROUND_W = 6
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               ap_idle,
  output logic               ap_ready,
  output logic               ark_start,
  input  logic               ark_done,
  output logic [ROUND_W-1:0] ark_n,
  output logic               sb_start,
  input  logic               sb_done,
  output logic               sr_start,
  input  logic               sr_done,
  output logic               mc_start,
  input  logic               mc_done,
  output logic [ROUND_W-1:0] round
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARK  = 3'd1,
    ST_SB   = 3'd2,
    ST_SR   = 3'd3,
    ST_MC   = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

  state_t     state_reg;
  // Sub-block start strobes, bit order {mc, sr, sb, ark}. Loaded together with
  // the state so that each strobe is high exactly while its state is current.
  logic [3:0] start_reg;

  function automatic logic [3:0] start_for(input state_t s);
    logic [3:0] v;
    v = 4'b0000;
    case (s)
      ST_ARK:  v = 4'b0001;
      ST_SB:   v = 4'b0010;
      ST_SR:   v = 4'b0100;
      ST_MC:   v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg <= ST_IDLE;
      start_reg <= 4'b0000;
      round     <= '0;
      ark_n     <= '0;
      ap_done   <= 1'b0;
      ap_ready  <= 1'b0;
    end else begin
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (ap_start) begin
            state_reg <= ST_ARK;
            start_reg <= start_for(ST_ARK);
            round     <= '0;
            ark_n     <= '0;
          end
        end
        ST_ARK: begin
          if (ark_done) begin
            if (round == LAST_ROUND) begin
              // Completion pulse is loaded here so it is high during FIN.
              state_reg <= ST_FIN;
              start_reg <= 4'b0000;
              ap_done   <= 1'b1;
              ap_ready  <= 1'b1;
            end else begin
              // Round advances only when leaving ARK; ark_n tracks it so
              // it is already stable when the next ARK begins.
              round     <= round + 1'b1;
              ark_n     <= round + 1'b1;
              state_reg <= ST_SB;
              start_reg <= start_for(ST_SB);
            end
          end
        end
        ST_SB: begin
          if (sb_done) begin
            state_reg <= ST_SR;
            start_reg <= start_for(ST_SR);
          end
        end
        ST_SR: begin
          if (sr_done) begin
            // The final round skips mix_column.
            if (round == LAST_ROUND) begin
              state_reg <= ST_ARK;
              start_reg <= start_for(ST_ARK);
            end else begin
              state_reg <= ST_MC;
              start_reg <= start_for(ST_MC);
            end
          end
        end
        ST_MC: begin
          if (mc_done) begin
            state_reg <= ST_ARK;
            start_reg <= start_for(ST_ARK);
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
          start_reg <= 4'b0000;
        end
        default: begin
          state_reg <= ST_IDLE;
          start_reg <= 4'b0000;
        end
      endcase
    end
  end

  assign ark_start = start_reg[0];
  assign sb_start  = start_reg[1];
  assign sr_start  = start_reg[2];
  assign mc_start  = start_reg[3];
  assign ap_idle   = (state_reg == ST_IDLE) && !ap_start;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer
//   Three sequencers (NR = 10, 1, 14) share one stimulus. Each has four
//   sub-block models with programmable done latency and injectable spurious
//   done pulses. A stage-list model predicts start strobes, ark_n, round and
//   completion pulses every cycle; literal values pin the model.
module tb_aes_round_sequencer;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n;
  logic       ap_start;
  logic [3:0] spur;
  bit         rand_mode;

  wire [2:0]  done_v, idle_v, ready_v;
  wire [3:0]  st_v   [3];   // {mc, sr, sb, ark}
  wire [3:0]  dn_v   [3];
  wire [5:0]  arkn_v [3];
  wire [5:0]  round_v[3];

  int cnt    [3][4];
  int lat_cur[3][4] = '{default: 1};

  int errs = 0, checks = 0, cyc = 0;
  int ms[3], pos[3], acc_cyc[3], last_lat[3], ndone[3];
  int inv[3][4];
  logic [5:0] last_ark[3];
  int s_chk, s_mdl;
  logic [6:0] act_v, exp_v;

  always #5 ap_clk = ~ap_clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    aes_round_sequencer #(.NR(gi == 0 ? 10 : (gi == 1 ? 1 : 14)), .ROUND_W(6)) u_dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .ap_start (ap_start),
      .ap_done  (done_v[gi]),
      .ap_idle  (idle_v[gi]),
      .ap_ready (ready_v[gi]),
      .ark_start(st_v[gi][0]),
      .ark_done (dn_v[gi][0]),
      .ark_n    (arkn_v[gi]),
      .sb_start (st_v[gi][1]),
      .sb_done  (dn_v[gi][1]),
      .sr_start (st_v[gi][2]),
      .sr_done  (dn_v[gi][2]),
      .mc_start (st_v[gi][3]),
      .mc_done  (dn_v[gi][3]),
      .round    (round_v[gi])
    );
    // Sub-block: acknowledges after lat_cur cycles of start; spurious done
    // only while not started (an idle HLS block may raise ap_done).
    for (genvar bi = 0; bi < 4; bi++) begin : g_blk
      assign dn_v[gi][bi] = (st_v[gi][bi] && (cnt[gi][bi] >= lat_cur[gi][bi] - 1)) ||
                            (spur[bi] && !st_v[gi][bi]);
    end
  end

  always @(posedge ap_clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (st_v[i][b] && dn_v[i][b]) begin
          cnt[i][b]     <= 0;
          lat_cur[i][b] <= rand_mode ? int'($urandom_range(20, 1)) : 1;
        end else if (st_v[i][b]) begin
          cnt[i][b] <= cnt[i][b] + 1;
        end else begin
          cnt[i][b] <= 0;
        end
      end
    end
  end

  function automatic int nr_of(input int i);
    return (i == 0) ? 10 : ((i == 1) ? 1 : 14);
  endfunction

  // Stage k of a sequence: 0=ARK 1=SB 2=SR 3=MC.
  function automatic int stage_at(input int nr, input int k);
    int r, ph;
    if (k == 0) return 0;
    r  = (k - 1) / 4 + 1;
    ph = (k - 1) % 4;
    if (r == nr && ph == 2) return 0;
    return (ph == 3) ? 0 : ph + 1;
  endfunction

  function automatic int round_at(input int k);
    return (k == 0) ? 0 : (k - 1) / 4 + 1;
  endfunction

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk(st_v[i] == 4'b0 && !done_v[i] && !ready_v[i] && round_v[i] == 6'd0 &&
          arkn_v[i] == 6'd0 && idle_v[i],
          $sformatf("%s[%0d]", tag, i),
          {st_v[i], done_v[i], ready_v[i], idle_v[i], round_v[i], arkn_v[i]},
          {4'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0});
    end
  endtask

  task automatic check_inv(input string tag);
    for (int i = 0; i < 3; i++) begin
      longint a, e;
      a = inv[i][0] * 1000000 + inv[i][1] * 10000 + inv[i][2] * 100 + inv[i][3];
      e = (i == 0) ? 11101009 : ((i == 1) ? 2010100 : 15141413);
      chk(a == e, $sformatf("%s_inv[%0d]", tag, i), a, e);
    end
  endtask

  function automatic bit all_idle();
    return ms[0] == 0 && ms[1] == 0 && ms[2] == 0;
  endfunction

  task automatic wait_idle(input bit spur_on, input int limit, input string tag);
    for (int k = 0; k < limit; k++) begin
      if (all_idle()) break;
      @(posedge ap_clk);
      #1;
      if (spur_on) spur = 4'($urandom);
    end
    spur = 4'b0;
    if (!all_idle()) chk(1'b0, {tag, "_timeout"}, ms[0], 0);
  endtask

  task automatic run_seq(input bit spur_on, input int limit, input string tag);
    int n0[3];
    for (int i = 0; i < 3; i++) n0[i] = ndone[i];
    @(posedge ap_clk);
    #1 ap_start = 1'b1;
    if (spur_on) spur = 4'($urandom);
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    wait_idle(spur_on, limit, tag);
    for (int i = 0; i < 3; i++)
      chk(ndone[i] - n0[i] == 1, $sformatf("%s_done_count[%0d]", tag, i), ndone[i] - n0[i], 1);
  endtask

  initial begin
    int d0;
    bit hit;
    ap_rst_n  = 1'b0;
    ap_start  = 1'b0;
    spur      = 4'b0;
    rand_mode = 1'b0;

    fork
      // Model: advances through the expected stage list on sampled handshakes.
      forever begin
        @(posedge ap_clk or negedge ap_rst_n);
        if (!ap_rst_n) begin
          for (int i = 0; i < 3; i++) begin
            ms[i]  = 0;
            pos[i] = 0;
          end
        end else begin
          for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 4; b++)
              if (st_v[i][b] && dn_v[i][b]) inv[i][b]++;
            case (ms[i])
              0: if (ap_start) begin
                ms[i]      = 1;
                pos[i]     = 0;
                acc_cyc[i] = cyc;
                for (int b = 0; b < 4; b++) inv[i][b] = 0;
              end
              1: begin
                s_mdl = stage_at(nr_of(i), pos[i]);
                if (dn_v[i][s_mdl]) begin
                  if (pos[i] == 4 * nr_of(i) - 1) last_ark[i] = arkn_v[i];
                  pos[i]++;
                  if (pos[i] == 4 * nr_of(i)) ms[i] = 2;
                end
              end
              default: ms[i] = 0;
            endcase
          end
        end
      end
      // Compare: every cycle, mid-cycle.
      forever begin
        @(negedge ap_clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
          s_chk = (ms[i] == 1) ? stage_at(nr_of(i), pos[i]) : 0;
          exp_v = {(ms[i] == 1) ? 4'(1 << s_chk) : 4'd0, ms[i] == 2, ms[i] == 2,
                   ms[i] == 0 && !ap_start};
          act_v = {st_v[i], done_v[i], ready_v[i], idle_v[i]};
          chk(act_v == exp_v, $sformatf("ctrl[%0d]@%0d", i, cyc), act_v, exp_v);
          if (ms[i] == 1) begin
            chk(int'(round_v[i]) == round_at(pos[i]), $sformatf("round[%0d]@%0d", i, cyc),
                round_v[i], round_at(pos[i]));
            if (s_chk == 0)
              chk(int'(arkn_v[i]) == round_at(pos[i]), $sformatf("ark_n[%0d]@%0d", i, cyc),
                  arkn_v[i], round_at(pos[i]));
          end
          if (ms[i] == 2)
            chk(int'(round_v[i]) == nr_of(i), $sformatf("fin_round[%0d]", i), round_v[i], nr_of(i));
          if (done_v[i]) begin
            ndone[i]++;
            last_lat[i] = cyc - acc_cyc[i] + 1;
          end
        end
      end
    join_none

    repeat (2) @(posedge ap_clk);
    #1 check_reset_outputs("reset");
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;

    // Single-cycle sub-blocks.
    run_seq(1'b0, 300, "t1");
    chk(last_lat[0] == 42, "t1_latency_nr10", last_lat[0], 42);
    chk(last_lat[1] == 6,  "t1_latency_nr1",  last_lat[1], 6);
    chk(last_lat[2] == 58, "t1_latency_nr14", last_lat[2], 58);
    chk(last_ark[0] == 6'd10, "t1_final_ark_nr10", last_ark[0], 10);
    chk(last_ark[1] == 6'd1,  "t1_final_ark_nr1",  last_ark[1], 1);
    chk(last_ark[2] == 6'd14, "t1_final_ark_nr14", last_ark[2], 14);
    check_inv("t1");

    // Random 1..20 cycle sub-block latencies.
    rand_mode = 1'b1;
    run_seq(1'b0, 3000, "t2");
    check_inv("t2");

    // Spurious done pulses in idle and during the sequence.
    repeat (6) begin
      @(posedge ap_clk);
      #1 spur = 4'($urandom);
    end
    spur = 4'b0;
    run_seq(1'b1, 3000, "t3");
    check_inv("t3");

    // Reset during round 5 mix_column of the NR=10 instance.
    rand_mode = 1'b0;
    @(posedge ap_clk);
    #1 ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge ap_clk);
      if (round_v[0] == 6'd5 && st_v[0][3]) begin
        hit = 1'b1;
        break;
      end
    end
    chk(hit, "t4_reach_round5_mc", hit, 1);
    #2 ap_rst_n = 1'b0;
    #1 check_reset_outputs("t4_async_reset");
    @(posedge ap_clk);
    #1 check_reset_outputs("t4_held_reset");
    ap_rst_n = 1'b1;
    run_seq(1'b0, 600, "t4_restart");
    check_inv("t4");

    // ap_start held high: back-to-back sequences with one idle bubble.
    d0 = ndone[0];
    @(posedge ap_clk);
    #1 ap_start = 1'b1;
    repeat (200) @(posedge ap_clk);
    #1 ap_start = 1'b0;
    wait_idle(1'b0, 200, "t6");
    chk(ndone[0] - d0 >= 4, "t6_b2b_done_count", ndone[0] - d0, 4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
